// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - fixed-point types, constants and activation helpers for the LSTM layer
//
// Contents:
//   Q_WIDTH / Q_FRAC : word width and fractional bits of the signed Q format
//   ACC_W            : dot-product accumulator width (headroom for long sums)
//   ONE / HALF       : 1.0 and 0.5 in the Q format
//   ext              : sign-extend a word to accumulator width
//   sat              : saturate an accumulator value back to a word
//   mul_q            : full-width multiply, arithmetic shift by Q_FRAC, saturate
//   hard_sigmoid     : clamp(z/4 + 0.5, 0, 1)
//   hard_tanh        : clamp(z, -1, 1)
package lstm_pkg;

    localparam int Q_WIDTH = 32;
    localparam int Q_FRAC  = 16;
    localparam int ACC_W   = Q_WIDTH + 8;
    localparam int PROD_W  = 2 * Q_WIDTH;

    typedef logic signed [Q_WIDTH-1:0] q_t;
    typedef logic signed [ACC_W-1:0]   acc_t;
    typedef logic signed [PROD_W-1:0]  prod_t;

    localparam q_t ONE   = q_t'(1 << Q_FRAC);
    localparam q_t HALF  = q_t'(1 << (Q_FRAC - 1));
    localparam q_t Q_MAX = {1'b0, {(Q_WIDTH-1){1'b1}}};
    localparam q_t Q_MIN = {1'b1, {(Q_WIDTH-1){1'b0}}};

    function automatic acc_t ext(input q_t v);
        return {{(ACC_W-Q_WIDTH){v[Q_WIDTH-1]}}, v};
    endfunction

    // In range when every bit above the word's sign bit matches the sign.
    function automatic q_t sat(input acc_t v);
        if (v[ACC_W-1:Q_WIDTH-1] == {(ACC_W-Q_WIDTH+1){v[ACC_W-1]}})
            return v[Q_WIDTH-1:0];
        else
            return v[ACC_W-1] ? Q_MIN : Q_MAX;
    endfunction

    // Products are saturated individually so a long dot product of large
    // terms cannot wrap the accumulator.
    function automatic q_t mul_q(input q_t a, input q_t b);
        prod_t ae;
        prod_t be;
        prod_t p;
        ae = {{Q_WIDTH{a[Q_WIDTH-1]}}, a};
        be = {{Q_WIDTH{b[Q_WIDTH-1]}}, b};
        p  = (ae * be) >>> Q_FRAC;
        if (p[PROD_W-1:Q_WIDTH-1] == {(PROD_W-Q_WIDTH+1){p[PROD_W-1]}})
            return p[Q_WIDTH-1:0];
        else
            return p[PROD_W-1] ? Q_MIN : Q_MAX;
    endfunction

    function automatic q_t hard_sigmoid(input q_t z);
        q_t t;
        t = (z >>> 2) + HALF;
        if (t < 0)
            return '0;
        else if (t > ONE)
            return ONE;
        else
            return t;
    endfunction

    function automatic q_t hard_tanh(input q_t z);
        if (z > ONE)
            return ONE;
        else if (z < -ONE)
            return -ONE;
        else
            return z;
    endfunction

endpackage

// File: rtl/lstm_cell.sv
// rtl/lstm_cell.sv - one LSTM cell: four gate dot products, activations, c/o/h state
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   sel           : 0 treats previous c as zero (hp arrives already gated)
//   load, load_h  : commit c/o_latch, then commit h (load wins if both high)
//   x             : shared input vector, element k at [k*Q_WIDTH +: Q_WIDTH]
//   hp            : gated previous hidden vector of the whole layer
//   w_a..w_o      : this cell's weight rows, x weights first, then h weights
//   b_a..b_o      : this cell's biases
//   h             : registered hidden output
module lstm_cell
    import lstm_pkg::*;
#(
    parameter int NUM      = 45,
    parameter int NUM_LSTM = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  sel,
    input  logic                                  load,
    input  logic                                  load_h,
    input  logic [NUM*Q_WIDTH-1:0]                x,
    input  logic [NUM_LSTM*Q_WIDTH-1:0]           hp,
    input  logic [(NUM+NUM_LSTM)*Q_WIDTH-1:0]     w_a,
    input  logic [(NUM+NUM_LSTM)*Q_WIDTH-1:0]     w_i,
    input  logic [(NUM+NUM_LSTM)*Q_WIDTH-1:0]     w_f,
    input  logic [(NUM+NUM_LSTM)*Q_WIDTH-1:0]     w_o,
    input  logic [Q_WIDTH-1:0]                    b_a,
    input  logic [Q_WIDTH-1:0]                    b_i,
    input  logic [Q_WIDTH-1:0]                    b_f,
    input  logic [Q_WIDTH-1:0]                    b_o,
    output logic [Q_WIDTH-1:0]                    h
);

    localparam int VLEN = NUM + NUM_LSTM;

    logic [VLEN*Q_WIDTH-1:0] v;
    q_t z_a_q, z_i_q, z_f_q, z_o_q;
    q_t c_reg, h_reg, o_latch;
    q_t act_a, act_i, act_f, act_o, cp, c_next, h_next;

    function automatic q_t dot(input logic [VLEN*Q_WIDTH-1:0] w,
                               input logic [VLEN*Q_WIDTH-1:0] vec,
                               input q_t b);
        acc_t acc;
        acc = ext(b);
        for (int k = 0; k < VLEN; k++)
            acc = acc + ext(mul_q(w[k*Q_WIDTH +: Q_WIDTH], vec[k*Q_WIDTH +: Q_WIDTH]));
        return sat(acc);
    endfunction

    assign v = {hp, x};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_a_q <= '0;
            z_i_q <= '0;
            z_f_q <= '0;
            z_o_q <= '0;
        end else begin
            z_a_q <= dot(w_a, v, b_a);
            z_i_q <= dot(w_i, v, b_i);
            z_f_q <= dot(w_f, v, b_f);
            z_o_q <= dot(w_o, v, b_o);
        end
    end

    always_comb begin
        act_a  = hard_tanh(z_a_q);
        act_i  = hard_sigmoid(z_i_q);
        act_f  = hard_sigmoid(z_f_q);
        act_o  = hard_sigmoid(z_o_q);
        cp     = sel ? c_reg : '0;
        c_next = sat(ext(mul_q(act_f, cp)) + ext(mul_q(act_i, act_a)));
        h_next = mul_q(o_latch, hard_tanh(c_reg));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_reg   <= '0;
            o_latch <= '0;
            h_reg   <= '0;
        end else if (load) begin
            c_reg   <= c_next;
            o_latch <= act_o;
        end else if (load_h) begin
            h_reg   <= h_next;
        end
    end

    assign h = h_reg;

endmodule

// File: rtl/lstm_array.sv
// rtl/lstm_array.sv - layer of NUM_LSTM LSTM cells sharing x_t and the layer's h_{t-1}
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   sel             : 0 on the first step (previous h/c read as zero)
//   load, load_h    : one-cycle strobes committing c, then h
//   i_x             : input vector, element k at [k*WIDTH +: WIDTH]
//   i_w_a..i_w_o    : weight rows, row n at [n*(NUM+NUM_LSTM)*WIDTH +: (NUM+NUM_LSTM)*WIDTH]
//   i_b_a..i_b_o    : biases, cell n at [n*WIDTH +: WIDTH]
//   o_h             : registered hidden vector, cell n at [n*WIDTH +: WIDTH]
module lstm_array
    import lstm_pkg::*;
#(
    parameter int WIDTH          = Q_WIDTH,
    parameter int FRAC           = Q_FRAC,
    parameter int NUM            = 45,
    parameter int NUM_LSTM       = 8,
    parameter int NUM_ITERATIONS = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     sel,
    input  logic                                     load,
    input  logic                                     load_h,
    input  logic [NUM*WIDTH-1:0]                     i_x,
    input  logic [NUM_LSTM*(NUM+NUM_LSTM)*WIDTH-1:0] i_w_a,
    input  logic [NUM_LSTM*(NUM+NUM_LSTM)*WIDTH-1:0] i_w_i,
    input  logic [NUM_LSTM*(NUM+NUM_LSTM)*WIDTH-1:0] i_w_f,
    input  logic [NUM_LSTM*(NUM+NUM_LSTM)*WIDTH-1:0] i_w_o,
    input  logic [NUM_LSTM*WIDTH-1:0]                i_b_a,
    input  logic [NUM_LSTM*WIDTH-1:0]                i_b_i,
    input  logic [NUM_LSTM*WIDTH-1:0]                i_b_f,
    input  logic [NUM_LSTM*WIDTH-1:0]                i_b_o,
    output logic [NUM_LSTM*WIDTH-1:0]                o_h
);

    localparam int ROW_W = (NUM + NUM_LSTM) * WIDTH;

    // The arithmetic helpers are built for the package's Q format only.
    if (WIDTH != Q_WIDTH || FRAC != Q_FRAC || NUM_ITERATIONS < 1) begin : g_param_check
        $error("lstm_array: WIDTH/FRAC must match lstm_pkg and NUM_ITERATIONS >= 1");
    end

    logic [NUM_LSTM*WIDTH-1:0] h_all;
    logic [NUM_LSTM*WIDTH-1:0] hp;

    assign hp  = sel ? h_all : '0;
    assign o_h = h_all;

    for (genvar n = 0; n < NUM_LSTM; n++) begin : g_cell
        lstm_cell #(
            .NUM      (NUM),
            .NUM_LSTM (NUM_LSTM)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .sel    (sel),
            .load   (load),
            .load_h (load_h),
            .x      (i_x),
            .hp     (hp),
            .w_a    (i_w_a[n*ROW_W +: ROW_W]),
            .w_i    (i_w_i[n*ROW_W +: ROW_W]),
            .w_f    (i_w_f[n*ROW_W +: ROW_W]),
            .w_o    (i_w_o[n*ROW_W +: ROW_W]),
            .b_a    (i_b_a[n*WIDTH +: WIDTH]),
            .b_i    (i_b_i[n*WIDTH +: WIDTH]),
            .b_f    (i_b_f[n*WIDTH +: WIDTH]),
            .b_o    (i_b_o[n*WIDTH +: WIDTH]),
            .h      (h_all[n*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_lstm_array.sv
// tb/tb_lstm_array.sv - directed self-checking bench for lstm_array
module tb_lstm_array;

    localparam int W    = 32;
    localparam int NUM  = 45;
    localparam int NL   = 8;
    localparam int VL   = NUM + NL;
    localparam int WBUS = NL * VL * W;

    logic            clk = 1'b0;
    logic            rst;
    logic            sel;
    logic            load;
    logic            load_h;
    logic [NUM*W-1:0] x;
    logic [WBUS-1:0]  w_a, w_i, w_f, w_o;
    logic [NL*W-1:0]  b_a, b_i, b_f, b_o;
    logic [NL*W-1:0]  o_h;

    int checks   = 0;
    int failures = 0;

    lstm_array #(
        .WIDTH(W), .FRAC(16), .NUM(NUM), .NUM_LSTM(NL), .NUM_ITERATIONS(8)
    ) dut (
        .clk(clk), .rst(rst), .sel(sel), .load(load), .load_h(load_h),
        .i_x(x),
        .i_w_a(w_a), .i_w_i(w_i), .i_w_f(w_f), .i_w_o(w_o),
        .i_b_a(b_a), .i_b_i(b_i), .i_b_f(b_f), .i_b_o(b_o),
        .o_h(o_h)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bias(input int g, input logic [W-1:0] val);
        for (int n = 0; n < NL; n++) begin
            case (g)
                0: b_a[n*W +: W] = val;
                1: b_i[n*W +: W] = val;
                2: b_f[n*W +: W] = val;
                default: b_o[n*W +: W] = val;
            endcase
        end
    endtask

    // Element k of every cell's row for gate g.
    task automatic set_w(input int g, input int k, input logic [W-1:0] val);
        for (int n = 0; n < NL; n++) begin
            case (g)
                0: w_a[(n*VL+k)*W +: W] = val;
                1: w_i[(n*VL+k)*W +: W] = val;
                2: w_f[(n*VL+k)*W +: W] = val;
                default: w_o[(n*VL+k)*W +: W] = val;
            endcase
        end
    endtask

    task automatic step();
        tick();
        tick();
        load = 1'b1;
        tick();
        load = 1'b0;
        load_h = 1'b1;
        tick();
        load_h = 1'b0;
    endtask

    task automatic check_oh(input string tag, input logic [W-1:0] exp);
        for (int n = 0; n < NL; n++) begin
            checks++;
            assert (o_h[n*W +: W] === exp) else begin
                failures++;
                $error("FAIL %s cell=%0d got=%h exp=%h", tag, n, o_h[n*W +: W], exp);
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        // 1. reset with random inputs
        rst = 1'b1; sel = 1'b1; load = 1'b0; load_h = 1'b0;
        for (int k = 0; k < NUM; k++) x[k*W +: W] = $urandom;
        for (int k = 0; k < NL*VL; k++) begin
            w_a[k*W +: W] = $urandom; w_i[k*W +: W] = $urandom;
            w_f[k*W +: W] = $urandom; w_o[k*W +: W] = $urandom;
        end
        for (int k = 0; k < NL; k++) begin
            b_a[k*W +: W] = $urandom; b_i[k*W +: W] = $urandom;
            b_f[k*W +: W] = $urandom; b_o[k*W +: W] = $urandom;
        end
        tick(); tick();
        check_oh("reset", 32'h0);
        rst = 1'b0;
        x = '0; w_a = '0; w_i = '0; w_f = '0; w_o = '0;
        b_a = '0; b_i = '0; b_f = '0; b_o = '0;
        sel = 1'b0;
        tick();
        load_h = 1'b1;
        tick();
        load_h = 1'b0;
        check_oh("load_h_only", 32'h0);

        // 2. first step: a=0.5, i=1, f=0.5, o=1 -> c=0.5, h=0.5
        set_bias(0, 32'h0000_8000);
        set_bias(1, 32'h0002_0000);
        set_bias(2, 32'h0000_0000);
        set_bias(3, 32'h0002_0000);
        step();
        check_oh("first_step", 32'h0000_8000);

        // 3. recurrence: f=1 -> c=1.0 then 1.5, h clamps at 1.0
        sel = 1'b1;
        set_bias(2, 32'h0002_0000);
        step();
        check_oh("recur_c1", 32'h0001_0000);
        step();
        check_oh("recur_c1p5", 32'h0001_0000);

        // 4. sel gating of the h weight (f=0 so c = i*a)
        set_w(0, NUM, 32'h0001_0000);
        set_bias(0, 32'h0000_0000);
        set_bias(2, 32'hFFFE_0000);
        sel = 1'b0;
        step();
        check_oh("sel0_gated", 32'h0000_0000);
        set_bias(0, 32'h0001_0000);
        step();                       // rebuild h_reg = 1.0
        set_bias(0, 32'h0000_0000);
        sel = 1'b1;
        step();
        check_oh("sel1_hweight", 32'h0001_0000);

        // 5. simultaneous strobes: c=0.5 committed, h unchanged until load_h
        sel = 1'b0;
        set_bias(0, 32'h0000_8000);
        tick(); tick();
        load = 1'b1; load_h = 1'b1;
        tick();
        load = 1'b0; load_h = 1'b0;
        check_oh("both_strobes", 32'h0001_0000);
        load_h = 1'b1;
        tick();
        load_h = 1'b0;
        check_oh("after_both", 32'h0000_8000);
        // reset between load and load_h
        tick();
        load = 1'b1;
        tick();
        load = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_oh("mid_reset", 32'h0000_0000);
        load_h = 1'b1;
        tick();
        load_h = 1'b0;
        check_oh("post_reset_h", 32'h0000_0000);

        // 6. saturation
        for (int k = 0; k < NUM; k++) x[k*W +: W] = 32'h7FFF_0000;
        for (int k = 0; k < NL*VL; k++) begin
            w_a[k*W +: W] = 32'h7FFF_0000; w_i[k*W +: W] = 32'h7FFF_0000;
            w_f[k*W +: W] = 32'h7FFF_0000; w_o[k*W +: W] = 32'h7FFF_0000;
        end
        b_a = '0; b_i = '0; b_f = '0; b_o = '0;
        sel = 1'b0;
        tick(); tick();
        check_val("z_i_sat_pos", dut.g_cell[0].u_cell.z_i_q, 32'h7FFF_FFFF);
        check_val("z_a_sat_pos", dut.g_cell[3].u_cell.z_a_q, 32'h7FFF_FFFF);
        step();
        check_oh("sat_pos_h", 32'h0001_0000);
        for (int k = 0; k < NL*VL; k++) w_a[k*W +: W] = 32'h8000_0000;
        tick(); tick();
        check_val("z_a_sat_neg", dut.g_cell[0].u_cell.z_a_q, 32'h8000_0000);
        step();
        check_oh("sat_neg_h", 32'hFFFF_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
